// File: rtl/m_btn_reduce.sv
// Debounced push-button bank with registered AND/OR/XOR reductions,
// an any-pressed rise pulse and a saturating all-pressed event counter.
module m_btn_reduce #(
  parameter int WIDTH     = 5,
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 8
) (
  input  logic             w_clk,
  input  logic             w_rst,
  input  logic [WIDTH-1:0] w_btn,
  input  logic             w_clr,
  output logic [WIDTH-1:0] w_stable,
  output logic [2:0]       w_led,
  output logic             w_any_rise,
  output logic [CNT_W-1:0] w_all_cnt
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DB_CYCLES - 1);

  logic [WIDTH-1:0]         s1_q, s2_q;
  logic [WIDTH-1:0]         db_q, db_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [2:0]               led_q, led_d;
  logic                     rise_q, rise_d;
  logic                     led0_q;
  logic [CNT_W-1:0]         all_q, all_d;
  logic                     all_rise;

  // A bit is accepted only after DB_CYCLES consecutive mismatching samples
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CMAX) db_d[i] = s2_q[i];
        else cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_comb begin
    led_d  = {^db_q, |db_q, &db_q};
    rise_d = (|db_q) & ~led_q[1];
  end

  assign all_rise = led_q[0] & ~led0_q;

  always_comb begin
    all_d = all_q;
    if (w_clr) all_d = '0;
    else if (all_rise && all_q != '1) all_d = all_q + CNT_W'(1);
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      db_q   <= '0;
      cnt_q  <= '0;
      led_q  <= '0;
      rise_q <= 1'b0;
      led0_q <= 1'b0;
      all_q  <= '0;
    end else begin
      s1_q   <= w_btn;
      s2_q   <= s1_q;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
      led_q  <= led_d;
      rise_q <= rise_d;
      led0_q <= led_q[0];
      all_q  <= all_d;
    end
  end

  assign w_stable   = db_q;
  assign w_led      = led_q;
  assign w_any_rise = rise_q;
  assign w_all_cnt  = all_q;

endmodule

// File: tb/tb_m_btn_reduce.sv
// Self-checking bench for m_btn_reduce: cycle model scoreboard
// plus directed latency, saturation, clear and async-reset checks.
module tb_m_btn_reduce;

  localparam int W  = 5;
  localparam int DB = 4;
  localparam int CN = 4;

  logic          clk, rst, clr;
  logic [W-1:0]  btn;
  logic [W-1:0]  stable;
  logic [2:0]    led;
  logic          any_rise;
  logic [CN-1:0] all_cnt;

  int checks = 0;
  int errors = 0;

  m_btn_reduce #(.WIDTH(W), .DB_CYCLES(DB), .CNT_W(CN)) dut (
    .w_clk(clk),
    .w_rst(rst),
    .w_btn(btn),
    .w_clr(clr),
    .w_stable(stable),
    .w_led(led),
    .w_any_rise(any_rise),
    .w_all_cnt(all_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  logic [W-1:0]  m_s1, m_s2, m_db;
  int            m_cnt [W];
  logic [2:0]    m_led;
  logic          m_rise, m_led0;
  logic [CN-1:0] m_all;
  logic [12:0]   sb_q [$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_db = '0;
      for (int i = 0; i < W; i++) m_cnt[i] = 0;
      m_led = '0; m_rise = 1'b0; m_led0 = 1'b0; m_all = '0;
      sb_q.delete();
    end else begin
      if (clr) m_all = '0;
      else if (m_led[0] && !m_led0 && m_all != {CN{1'b1}})
        m_all = m_all + 1'b1;
      m_led0 = m_led[0];
      m_rise = (m_db != 0) && !m_led[1];
      m_led  = {^m_db, |m_db, &m_db};
      for (int i = 0; i < W; i++) begin
        if (m_s2[i] == m_db[i]) m_cnt[i] = 0;
        else if (m_cnt[i] == DB - 1) begin
          m_db[i] = m_s2[i];
          m_cnt[i] = 0;
        end else m_cnt[i]++;
      end
      m_s2 = m_s1;
      m_s1 = btn;
      sb_q.push_back({m_db, m_led, m_rise, m_all});
    end
  end

  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      logic [12:0] e;
      e = sb_q.pop_front();
      chk("sb", {stable, led, any_rise, all_cnt}, e);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int pulses;
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (any_rise) pulses++;
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; btn = '0;
    #1;
    chk("rst_out", {stable, led, any_rise, all_cnt}, 0);
    #22 rst = 1'b0;
    run(10);

    // press all: latency check
    btn = 5'b11111;
    run(5);
    chk("stab_k4", stable, 5'b00000);
    tick();
    chk("stab_k5", stable, 5'b11111);
    chk("led_k5", led, 3'b000);
    tick();
    chk("led_k6", led, 3'b111);
    chk("rise_k6", any_rise, 1);
    chk("cnt_k6", all_cnt, 0);
    tick();
    chk("rise_k7", any_rise, 0);
    chk("cnt_k7", all_cnt, 1);

    // from all pressed to one bit
    pulses = 0;
    btn = 5'b00010;
    run(12);
    chk("led_one", led, 3'b110);
    chk("no_pulse", pulses, 0);
    chk("cnt_hold", all_cnt, 1);

    // glitch rejection
    btn = '0;
    run(12);
    pulses = 0;
    btn = 5'b00001;
    run(3);
    btn = '0;
    run(12);
    chk("glitch_st", stable, 5'b00000);
    chk("glitch_led", led, 3'b000);
    chk("glitch_p", pulses, 0);
    btn = 5'b00001;
    run(10);
    chk("long_led", led, 3'b110);
    chk("long_p", pulses, 1);

    // saturation
    btn = '0;
    run(12);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr0", all_cnt, 0);
    for (int c = 0; c < 17; c++) begin
      btn = 5'b11111; run(8);
      btn = 5'b00000; run(8);
    end
    run(4);
    chk("sat15", all_cnt, 15);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_sat", all_cnt, 0);

    // clear wins over a simultaneous increment
    btn = 5'b11111;
    run(7);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_pri_led", led, 3'b111);
    chk("clr_pri", all_cnt, 0);
    run(4);
    chk("clr_pri_hold", all_cnt, 0);

    // async reset mid-debounce
    btn = '0;
    run(12);
    btn = 5'b11111;
    run(3);
    #2 rst = 1'b1;
    #1;
    chk("arst_out", {stable, led, any_rise, all_cnt}, 0);
    run(2);
    chk("arst_hold", {stable, led, any_rise, all_cnt}, 0);
    #3 rst = 1'b0;
    pulses = 0;
    run(6);
    chk("post_k5", led, 3'b000);
    tick();
    chk("post_k6", led, 3'b111);
    chk("post_rise", any_rise, 1);
    pulses++;
    run(4);
    chk("post_p", pulses, 1);
    chk("post_cnt", all_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_btn_reduce.md
# m_btn_reduce

Parametrised, registered reduction monitor for a bank of push-buttons or switches. Each input bit is synchronised and debounced, then AND/OR/XOR reductions of the clean vector drive LEDs. The block also emits an "any pressed" rising-edge pulse and keeps a saturating count of "all pressed" events. It sits between raw board inputs and LED/status logic in the lab top-levels.

## Interface

Parameters:
- `WIDTH`, 5, number of input bits (≥1).
- `DB_CYCLES`, 4, consecutive cycles a synchronised bit must differ from its debounced value before the change is accepted (≥1).
- `CNT_W`, 8, width of the all-pressed event counter (≥1).

Ports:
- `w_clk`  input  1  clock; all state changes on rising edge.
- `w_rst`  input  1  reset, asynchronous, active-high.
- `w_btn`  input  WIDTH  raw asynchronous inputs.
- `w_clr`  input  1  synchronous clear of `w_all_cnt`.
- `w_stable`  output  WIDTH  debounced input vector.
- `w_led`  output  3  registered reductions: [0]=&stable, [1]=|stable, [2]=^stable.
- `w_any_rise`  output  1  one-cycle pulse when `w_led[1]` goes 0→1.
- `w_all_cnt`  output  CNT_W  saturating count of `w_led[0]` 0→1 transitions.

## Operation

- Per bit: two-flop synchroniser s1←w_btn, s2←s1.
- Per-bit debounce counter `cnt`, width clog2(DB_CYCLES+1):
  - s2 == db: cnt←0.
  - s2 != db and cnt == DB_CYCLES-1: db←s2, cnt←0.
  - Otherwise cnt←cnt+1.
- Any return of s2 to db before acceptance resets cnt, so pulses shorter than DB_CYCLES cycles at s2 are rejected.
- `w_stable` = db vector (register output).
- Reductions are computed on db and registered into `w_led` one edge after db changes.
- `w_any_rise` is registered in the same edge as `w_led`: it is set to (|db) & ~w_led[1].
- `w_all_cnt` updates on the edge after `w_led[0]` is observed rising (led0 delayed-copy compare):
  - `w_clr`=1: cnt←0. Clear has priority over an increment in the same cycle.
  - Else rising and cnt != all-ones: cnt+1.
  - Else hold. The counter saturates at 2^CNT_W−1 and does not wrap.
- Bits are independent; simultaneous changes on several bits are each debounced separately. The reductions reflect whatever db holds at that edge.

## Timing

- Reset (async assert, any time) forces to 0 immediately: s1, s2, db, all cnt, `w_stable`, `w_led`, `w_any_rise`, `w_all_cnt`, led0 delay copy.
- Reset mid-debounce abandons progress. Inputs still held after reset release are re-debounced from scratch.
- Latency: let edge k be the first edge sampling a new stable level into s1.
  - s2 changes at edge k+1.
  - db/`w_stable` changes at edge k+1+DB_CYCLES.
  - `w_led` and `w_any_rise` change at edge k+2+DB_CYCLES.
  - `w_all_cnt` changes at edge k+3+DB_CYCLES.
- `w_any_rise` is high for exactly one cycle per 0→1 of `w_led[1]`. It never stays high across consecutive cycles.
- With DB_CYCLES=1, db follows s2 one edge later; there is no filtering beyond synchronisation.

## Test plan

WIDTH=5, DB_CYCLES=4, CNT_W=4.

- Reset, w_btn=00000 held 10 cycles, then w_btn=11111 → `w_stable`=11111 at edge k+5; `w_led`=111 at edge k+6; `w_any_rise` high exactly one cycle; `w_all_cnt`=1 at edge k+7.
- From 11111, w_btn=00010 held → `w_led`=110, no `w_any_rise` pulse, `w_all_cnt` unchanged at 1.
- From 00000, w_btn=00001 for 3 cycles then back to 00000 → `w_stable`=00000, `w_led`=000, no pulse. The same stimulus held 4+ cycles → `w_led`=110.
- 17 full press/release cycles of 11111/00000, each level held 8 cycles → `w_all_cnt` reads 15 and holds. Then one cycle of `w_clr` → 0.
- `w_clr` asserted in the exact cycle an all-pressed rise would increment → `w_all_cnt`=0.
- w_btn=11111; assert `w_rst` asynchronously 3 cycles into debounce → all outputs 0 without waiting for a clock edge. After deassert with w_btn still 11111 → `w_led`=111 at edge k+6 relative to the first post-reset sampling edge, plus one `w_any_rise` pulse.
